// File: rtl/inv_r_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : inv_r_sched_if
// Brief    : Handshake and RAM/VMU control bundle of the R-inverse sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface inv_r_sched_if #(
  parameter int K_W   = 4,
  parameter int IDX_W = 3
) ();

  logic                 start;
  logic [K_W-1:0]       k;
  logic                 busy;
  logic [IDX_W-1:0]     r_addr;
  logic                 r_oe;
  logic [IDX_W-1:0]     inv_rd_addr;
  logic                 inv_oe;
  logic                 inv_q_sel;
  logic [2*IDX_W-1:0]   inv_wr_addr;
  logic                 inv_we;
  logic [IDX_W-1:0]     div_addr;
  logic                 div_rd_en;
  logic                 vmu_en;
  logic                 identity_flag;
  logic                 done;

  // Controller side: requests an inverse and observes the RAM/VMU controls.
  modport master (
    output start, k,
    input  busy, r_addr, r_oe, inv_rd_addr, inv_oe, inv_q_sel,
           inv_wr_addr, inv_we, div_addr, div_rd_en, vmu_en,
           identity_flag, done
  );

  // Sequencer side.
  modport slave (
    input  start, k,
    output busy, r_addr, r_oe, inv_rd_addr, inv_oe, inv_q_sel,
           inv_wr_addr, inv_we, div_addr, div_rd_en, vmu_en,
           identity_flag, done
  );

endinterface
`default_nettype wire

// File: rtl/inv_r_sched.sv
`default_nettype none
// ============================================================================
// Module   : inv_r_sched
// Brief    : Walks every element of inv(R) column-major, diagonal first,
//            sequencing RAM reads, the VMU dot product and the result write.
// Revision : 1.0 - initial release
// ============================================================================
module inv_r_sched #(
  parameter int MAX_K   = 8,
  parameter int K_W     = 4,
  parameter int IDX_W   = 3,
  parameter int RAM_LAT = 1,
  parameter int VMU_LAT = 3
) (
  input  wire logic       clk,
  input  wire logic       rst,
  inv_r_sched_if.slave    bus
);

  localparam int CNT_MAX = (RAM_LAT > VMU_LAT) ? RAM_LAT : VMU_LAT;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam int CMP_W   = ((K_W > IDX_W) ? K_W : IDX_W) + 1;

  localparam logic [CNT_W-1:0] C_RAM_LAST = CNT_W'((RAM_LAT > 0) ? RAM_LAT - 1 : 0);
  localparam logic [CNT_W-1:0] C_VMU_LAST = CNT_W'((VMU_LAT > 0) ? VMU_LAT - 1 : 0);
  localparam logic [K_W-1:0]   C_MAX_K    = K_W'(MAX_K);

  // The NEXT decision is folded into WR, so it has no state of its own.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_MAC  = 3'd3,
    S_WR   = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   i_q, i_d;
  logic [IDX_W-1:0]   j_q, j_d;
  logic [K_W-1:0]     keff_q, keff_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [K_W-1:0]     w_k_sat;
  logic [CMP_W-1:0]   w_j_inc;
  logic               w_last_col;

  assign w_k_sat    = (bus.k > C_MAX_K) ? C_MAX_K : bus.k;
  assign w_j_inc    = CMP_W'(j_q) + CMP_W'(1);
  assign w_last_col = (w_j_inc >= CMP_W'(keff_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      keff_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      keff_q  <= keff_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    keff_d  = keff_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          keff_d  = w_k_sat;
          i_d     = '0;
          j_d     = '0;
          cnt_d   = '0;
          state_d = (w_k_sat == '0) ? S_FIN : S_RD;
        end
      end
      S_RD: begin
        cnt_d   = '0;
        state_d = (RAM_LAT > 0) ? S_WAIT : S_MAC;
      end
      S_WAIT: begin
        if (cnt_q == C_RAM_LAST) begin
          cnt_d   = '0;
          state_d = S_MAC;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_MAC: begin
        if (cnt_q == C_VMU_LAST) begin
          cnt_d   = '0;
          state_d = S_WR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WR: begin
        // Walk up the column; at row 0 step to the next column's diagonal.
        if (i_q != '0) begin
          i_d     = i_q - IDX_W'(1);
          state_d = S_RD;
        end else if (!w_last_col) begin
          j_d     = IDX_W'(w_j_inc);
          i_d     = IDX_W'(w_j_inc);
          state_d = S_RD;
        end else begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  logic w_rd, w_wait, w_mac, w_wr, w_active;

  always_comb begin
    w_rd     = (state_q == S_RD);
    w_wait   = (state_q == S_WAIT);
    w_mac    = (state_q == S_MAC);
    w_wr     = (state_q == S_WR);
    w_active = w_rd | w_wait | w_mac | w_wr;
  end

  assign bus.busy          = w_active;
  assign bus.r_oe          = w_rd;
  assign bus.inv_oe        = w_rd;
  assign bus.div_rd_en     = w_rd;
  // Column data must stay selected until the VMU has consumed it.
  assign bus.inv_q_sel     = w_rd | w_wait | w_mac;
  assign bus.vmu_en        = w_mac;
  assign bus.inv_we        = w_wr;
  assign bus.done          = (state_q == S_FIN);
  assign bus.identity_flag = w_active & (i_q == j_q);
  assign bus.r_addr        = i_q;
  assign bus.div_addr      = i_q;
  assign bus.inv_rd_addr   = j_q;
  assign bus.inv_wr_addr   = {j_q, i_q};

endmodule
`default_nettype wire

// File: tb/tb_inv_r_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_r_sched
// Brief    : Directed and random runs of inv_r_sched against a write-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inv_r_sched;

  localparam int MAX_K   = 8;
  localparam int K_W     = 4;
  localparam int IDX_W   = 3;
  localparam int RAM_LAT = 1;
  localparam int VMU_LAT = 3;
  localparam int P       = 2 + RAM_LAT + VMU_LAT;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  inv_r_sched_if #(.K_W(K_W), .IDX_W(IDX_W)) bus ();

  inv_r_sched #(
    .MAX_K(MAX_K), .K_W(K_W), .IDX_W(IDX_W), .RAM_LAT(RAM_LAT), .VMU_LAT(VMU_LAT)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [23:0] all_outs();
    return {bus.busy, bus.r_addr, bus.r_oe, bus.inv_rd_addr, bus.inv_oe, bus.inv_q_sel,
            bus.inv_wr_addr, bus.inv_we, bus.div_addr, bus.div_rd_en, bus.vmu_en,
            bus.identity_flag, bus.done};
  endfunction

  // One operation: start with kin; optionally re-pulse start at restart_at, or
  // assert rst at rst_at. Observed activity is compared with the model list.
  task automatic run(input int kin, input int restart_at, input int rst_at, input string tag);
    int keff, e, budget, nexp, lim;
    int exp_addr[$];
    int wr_cyc[$], wr_addr[$], wr_id[$];
    int done_cyc = -1, ndone = 0, vmu_n = 0, rd_n = 0;
    int first_vmu = -1, first_rd = -1, busy_err = 0, ovl_err = 0;
    logic exp_busy;

    keff = (kin > MAX_K) ? MAX_K : kin;
    e    = keff * (keff + 1) / 2;
    for (int jj = 0; jj < keff; jj++)
      for (int ii = jj; ii >= 0; ii--)
        exp_addr.push_back((jj << IDX_W) | ii);
    budget = P * e + 4;

    @(negedge clk);
    bus.start = 1'b1;
    bus.k     = K_W'(kin);
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (cyc == restart_at) begin
        bus.start = 1'b1;
        bus.k     = K_W'(2);
      end
      if (rst_at > 0 && cyc == rst_at) begin
        rst = 1'b1;
        #1;
        check({tag, " outs_zero_on_rst"}, 64'(all_outs()), 64'd0);
      end
      if (rst_at > 0 && cyc == rst_at + 1) rst = 1'b0;

      if (bus.inv_we) begin
        wr_cyc.push_back(cyc);
        wr_addr.push_back(int'(bus.inv_wr_addr));
        wr_id.push_back(int'(bus.identity_flag));
      end
      if (bus.done) begin
        ndone++;
        done_cyc = cyc;
      end
      if (bus.vmu_en) begin
        vmu_n++;
        if (first_vmu < 0) first_vmu = cyc;
      end
      if (bus.r_oe) begin
        rd_n++;
        if (first_rd < 0) first_rd = cyc;
      end
      exp_busy = (keff > 0) && (cyc <= P * e) && (rst_at == 0 || cyc < rst_at);
      if (bus.busy !== exp_busy) busy_err++;
      if ((bus.vmu_en && bus.inv_we) || ((bus.r_oe || bus.inv_oe) && bus.inv_we)) ovl_err++;
    end

    nexp = e;
    if (rst_at > 0) begin
      nexp = 0;
      while (nexp < e && P * (nexp + 1) < rst_at) nexp++;
    end
    check({tag, " n_writes"}, wr_cyc.size(), nexp);
    lim = (wr_cyc.size() < nexp) ? wr_cyc.size() : nexp;
    for (int n = 0; n < lim; n++) begin
      check({tag, " wr_addr"}, wr_addr[n], exp_addr[n]);
      check({tag, " wr_cycle"}, wr_cyc[n], P * (n + 1));
      check({tag, " wr_identity"}, wr_id[n], ((exp_addr[n] >> IDX_W) == (exp_addr[n] & (MAX_K - 1))) ? 1 : 0);
    end
    check({tag, " busy_profile_errs"}, busy_err, 0);
    check({tag, " overlap_errs"}, ovl_err, 0);
    if (rst_at > 0) begin
      check({tag, " no_done_after_rst"}, ndone, 0);
    end else begin
      check({tag, " done_count"}, ndone, 1);
      check({tag, " done_cycle"}, done_cyc, P * e + 1);
      check({tag, " vmu_cycles"}, vmu_n, VMU_LAT * e);
      check({tag, " rd_cycles"}, rd_n, e);
      if (e > 0) begin
        check({tag, " first_rd"}, first_rd, 1);
        check({tag, " first_vmu"}, first_vmu, 2 + RAM_LAT);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.k     = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'(all_outs()), 64'd0);
    rst = 1'b0;

    run(1, 0, 0, "k1");
    run(3, 0, 0, "k3");
    run(0, 0, 0, "k0");
    run(15, 0, 0, "k15_sat");
    run(8, 0, 0, "k8");
    run(3, 7, 0, "k3_restart_ignored");
    run(4, 0, 20, "k4_rst");
    run(2, 0, 0, "k2_after_rst");
    for (int r = 0; r < 4; r++) run(int'($urandom_range(0, 15)), 0, 0, "rnd");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
